// File: rtl/game_flow_ctrl_pkg.sv
// Shared game definitions: state encoding used by the flow controller, rendering and audio.
// Also holds the timer width and the terminal-count helper.
package game_flow_ctrl_pkg;

  localparam int STATE_W = 3;
  localparam int TMR_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_MENU  = 3'd0,
    ST_WIN   = 3'd1,
    ST_LOSE  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_SERVE = 3'd4,
    ST_PAUSE = 3'd5,
    ST_CLEAR = 3'd6
  } game_state_t;

  // Timer counts 0..ticks-1; the phase ends on the tick seen at the last count.
  function automatic logic [TMR_W-1:0] tc_of(input int ticks);
    return TMR_W'(ticks - 1);
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Game event inputs and flow-status outputs of the flow controller.
// master drives events (input/physics side); slave is the controller.
interface game_flow_ctrl_if;
  import game_flow_ctrl_pkg::*;

  logic        tick;
  logic        start;
  logic        pause;
  logic        bricks_empty;
  logic        ball_lost;
  game_state_t state;
  logic [2:0]  stage_idx;
  logic [2:0]  lives;
  logic        run;
  logic        load_stage;
  logic        serve;
  logic        life_lost;

  modport master (
    output tick, start, pause, bricks_empty, ball_lost,
    input  state, stage_idx, lives, run, load_stage, serve, life_lost
  );

  modport slave (
    input  tick, start, pause, bricks_empty, ball_lost,
    output state, stage_idx, lives, run, load_stage, serve, life_lost
  );

endinterface

// File: rtl/game_flow_ctrl_tick_timer.sv
// Shared 8-bit phase timer: synchronous clear, tick-qualified increment, terminal-count flag.
// Flag is combinational from the count register; no backpressure.
module tick_timer
  import game_flow_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [TMR_W-1:0] tc,
  output logic             at_tc
);

  logic [TMR_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + TMR_W'(1);
    end
  end

  assign at_tc = (cnt_q == tc);

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow FSM: menu/serve/play/pause/clear/win/lose, stage and life bookkeeping.
// All outputs registered, valid the cycle after the triggering input; no backpressure.
module game_flow_ctrl
  import game_flow_ctrl_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int LIVES       = 3,
  parameter int SERVE_TICKS = 20,
  parameter int CLEAR_TICKS = 40
) (
  input  logic           clk,
  input  logic           rst,
  game_flow_ctrl_if.slave gif
);

  localparam logic [2:0]       LAST_STAGE = 3'(NUM_STAGES - 1);
  localparam logic [2:0]       LIVES_INIT = 3'(LIVES);
  localparam logic [TMR_W-1:0] SERVE_TC   = tc_of(SERVE_TICKS);
  localparam logic [TMR_W-1:0] CLEAR_TC   = tc_of(CLEAR_TICKS);

  game_state_t state_q, state_d;
  logic [2:0]  stage_q, stage_d;
  logic [2:0]  lives_q, lives_d;
  logic        load_q, load_d;
  logic        serve_q, serve_d;
  logic        lost_q, lost_d;

  logic             tmr_en;
  logic             tmr_clr;
  logic             tmr_at_tc;
  logic             tmr_expire;
  logic [TMR_W-1:0] tmr_tc;

  // One timer serves both timed phases; any state change restarts it.
  assign tmr_en     = gif.tick && (state_q == ST_SERVE || state_q == ST_CLEAR);
  assign tmr_tc     = (state_q == ST_CLEAR) ? CLEAR_TC : SERVE_TC;
  assign tmr_expire = tmr_en && tmr_at_tc;
  assign tmr_clr    = (state_d != state_q);

  tick_timer u_tick_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .tc    (tmr_tc),
    .at_tc (tmr_at_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_MENU;
      stage_q <= '0;
      lives_q <= LIVES_INIT;
      load_q  <= 1'b0;
      serve_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      lives_q <= lives_d;
      load_q  <= load_d;
      serve_q <= serve_d;
      lost_q  <= lost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    lives_d = lives_q;
    load_d  = 1'b0;
    serve_d = 1'b0;
    lost_d  = 1'b0;
    case (state_q)
      ST_MENU: begin
        if (gif.start) begin
          state_d = ST_SERVE;
          stage_d = '0;
          lives_d = LIVES_INIT;
          load_d  = 1'b1;
          serve_d = 1'b1;
        end
      end
      ST_SERVE: begin
        if (tmr_expire) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // bricks_empty outranks ball_lost outranks pause; losers are dropped.
        if (gif.bricks_empty) begin
          state_d = (stage_q >= LAST_STAGE) ? ST_WIN : ST_CLEAR;
        end else if (gif.ball_lost) begin
          lost_d = 1'b1;
          if (lives_q <= 3'd1) begin
            lives_d = '0;
            state_d = ST_LOSE;
          end else begin
            lives_d = lives_q - 3'd1;
            serve_d = 1'b1;
            state_d = ST_SERVE;
          end
        end else if (gif.pause) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (gif.pause) state_d = ST_PLAY;
      end
      ST_CLEAR: begin
        if (tmr_expire) begin
          if (stage_q < LAST_STAGE) stage_d = stage_q + 3'd1;
          load_d  = 1'b1;
          serve_d = 1'b1;
          state_d = ST_SERVE;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (gif.start) state_d = ST_MENU;
      end
      default: state_d = ST_MENU;
    endcase
  end

  always_comb begin
    gif.state      = state_q;
    gif.stage_idx  = stage_q;
    gif.lives      = lives_q;
    gif.run        = (state_q == ST_PLAY);
    gif.load_stage = load_q;
    gif.serve      = serve_q;
    gif.life_lost  = lost_q;
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a per-cycle behavioural model and literal spot checks.
module tb_game_flow_ctrl;
  import game_flow_ctrl_pkg::*;

  localparam int NUM_STAGES  = 2;
  localparam int LIVES       = 2;
  localparam int SERVE_TICKS = 3;
  localparam int CLEAR_TICKS = 4;

  logic clk;
  logic rst;
  game_flow_ctrl_if gif ();

  game_flow_ctrl #(
    .NUM_STAGES  (NUM_STAGES),
    .LIVES       (LIVES),
    .SERVE_TICKS (SERVE_TICKS),
    .CLEAR_TICKS (CLEAR_TICKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .gif (gif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  // ---- behavioural model: ticks counted up to the phase length ----
  game_state_t m_state;
  int          m_stage, m_lives, m_ticks;
  bit          m_load, m_serve, m_lost;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= ST_MENU; m_stage <= 0; m_lives <= LIVES; m_ticks <= 0;
      m_load <= 0; m_serve <= 0; m_lost <= 0;
    end else begin
      m_load <= 0; m_serve <= 0; m_lost <= 0;
      case (m_state)
        ST_MENU: if (gif.start) begin
          m_state <= ST_SERVE; m_stage <= 0; m_lives <= LIVES; m_ticks <= 0;
          m_load <= 1; m_serve <= 1;
        end
        ST_SERVE: if (gif.tick) begin
          if (m_ticks + 1 == SERVE_TICKS) begin m_state <= ST_PLAY; m_ticks <= 0; end
          else m_ticks <= m_ticks + 1;
        end
        ST_PLAY: begin
          if (gif.bricks_empty) begin
            m_state <= (m_stage + 1 == NUM_STAGES) ? ST_WIN : ST_CLEAR;
            m_ticks <= 0;
          end else if (gif.ball_lost) begin
            m_lost  <= 1;
            m_lives <= m_lives - 1;
            if (m_lives - 1 == 0) m_state <= ST_LOSE;
            else begin m_state <= ST_SERVE; m_serve <= 1; m_ticks <= 0; end
          end else if (gif.pause) m_state <= ST_PAUSE;
        end
        ST_PAUSE: if (gif.pause) m_state <= ST_PLAY;
        ST_CLEAR: if (gif.tick) begin
          if (m_ticks + 1 == CLEAR_TICKS) begin
            m_state <= ST_SERVE; m_stage <= m_stage + 1; m_ticks <= 0;
            m_load <= 1; m_serve <= 1;
          end else m_ticks <= m_ticks + 1;
        end
        default: if (gif.start) m_state <= ST_MENU;
      endcase
    end
  end

  // ---- every-cycle comparison against the model ----
  initial begin
    logic [12:0] act, exp;
    forever begin
      @(negedge clk);
      if (armed && !rst) begin
        act = {gif.state, gif.stage_idx, gif.lives, gif.run, gif.load_stage, gif.serve, gif.life_lost};
        exp = {m_state, 3'(m_stage), 3'(m_lives), (m_state == ST_PLAY), m_load, m_serve, m_lost};
        total++;
        if (act !== exp) begin
          bad++;
          $display("FAIL model_cmp t=%0t: dut=%b model=%b (state,stage,lives,run,load,serve,lost)", $time, act, exp);
        end
      end
    end
  end

  // ---- free-running game tick, one clk every 4 ----
  int cyc = 0;
  initial begin
    gif.tick = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      gif.tick = (cyc % 4 == 0);
    end
  end

  int ticks_total = 0, n_load = 0, n_serve = 0, n_lost = 0;
  always @(posedge clk) begin
    ticks_total <= ticks_total + int'(gif.tick);
    n_load      <= n_load  + int'(gif.load_stage);
    n_serve     <= n_serve + int'(gif.serve);
    n_lost      <= n_lost  + int'(gif.life_lost);
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_state(input game_state_t s, input int budget, input string nm);
    int n = 0;
    while (gif.state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (gif.state !== s) begin
      bad++;
      $display("FAIL %s: state %0d want %0d after %0d cycles", nm, gif.state, s, budget);
    end
  endtask

  // mask bits: 3=start 2=pause 1=bricks_empty 0=ball_lost
  task automatic pulse(input logic [3:0] m);
    @(negedge clk);
    {gif.start, gif.pause, gif.bricks_empty, gif.ball_lost} = m;
    @(negedge clk);
    {gif.start, gif.pause, gif.bricks_empty, gif.ball_lost} = 4'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, l0, s0, x0, n;
    {gif.start, gif.pause, gif.bricks_empty, gif.ball_lost} = 4'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_state", int'(gif.state), 0);
    chk("rst_stage", int'(gif.stage_idx), 0);
    chk("rst_lives", int'(gif.lives), 2);
    chk("rst_pulses", int'({gif.run, gif.load_stage, gif.serve, gif.life_lost}), 0);
    idle(3);
    rst = 1'b0;
    armed = 1'b1;
    idle(2);
    chk("menu_idle", int'(gif.state), 0);

    // start, serve, play
    l0 = n_load; s0 = n_serve;
    pulse(4'b1000);
    chk("start_state", int'(gif.state), 4);
    chk("start_stage", int'(gif.stage_idx), 0);
    chk("start_lives", int'(gif.lives), 2);
    t0 = ticks_total;
    wait_state(ST_PLAY, 40, "serve_to_play");
    chk("serve_ticks", ticks_total - t0, 3);
    chk("play_run", int'(gif.run), 1);
    chk("start_load_once", n_load - l0, 1);
    chk("start_serve_once", n_serve - s0, 1);

    // two lost balls -> LOSE
    x0 = n_lost;
    pulse(4'b0001);
    chk("lost1_state", int'(gif.state), 4);
    chk("lost1_lives", int'(gif.lives), 1);
    wait_state(ST_PLAY, 40, "reserve_to_play");
    pulse(4'b0001);
    chk("lost2_state", int'(gif.state), 2);
    chk("lost2_lives", int'(gif.lives), 0);
    chk("lose_run", int'(gif.run), 0);
    idle(1);
    chk("lost_pulses", n_lost - x0, 2);
    pulse(4'b1000);
    chk("lose_to_menu", int'(gif.state), 0);
    chk("menu_lives_held", int'(gif.lives), 0);

    // clear stage 0, win on stage 1
    pulse(4'b1000);
    wait_state(ST_PLAY, 40, "g2_play");
    pulse(4'b0010);
    chk("bricks0_clear", int'(gif.state), 6);
    l0 = n_load;
    t0 = ticks_total;
    wait_state(ST_SERVE, 40, "clear_to_serve");
    chk("clear_ticks", ticks_total - t0, 4);
    chk("clear_stage", int'(gif.stage_idx), 1);
    idle(1);
    chk("clear_load", n_load - l0, 1);
    wait_state(ST_PLAY, 40, "s1_play");
    pulse(4'b0010);
    chk("bricks1_win", int'(gif.state), 1);
    pulse(4'b1000);
    chk("win_to_menu", int'(gif.state), 0);

    // coincident bricks_empty + ball_lost, then pause behaviour
    pulse(4'b1000);
    wait_state(ST_PLAY, 40, "g3_play");
    x0 = n_lost;
    pulse(4'b0011);
    chk("coinc_state", int'(gif.state), 6);
    chk("coinc_lives", int'(gif.lives), 2);
    wait_state(ST_PLAY, 80, "g3_s1_play");
    idle(1);
    chk("coinc_no_lost", n_lost - x0, 0);
    pulse(4'b0100);
    chk("pause_state", int'(gif.state), 5);
    chk("pause_run", int'(gif.run), 0);
    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b1000);
    chk("pause_ignore", int'(gif.state), 5);
    chk("pause_lives", int'(gif.lives), 2);
    pulse(4'b0100);
    chk("unpause", int'(gif.state), 3);
    pulse(4'b1000);
    chk("start_ignored_play", int'(gif.state), 3);
    pulse(4'b0010);
    chk("g3_win", int'(gif.state), 1);

    // reset in the middle of CLEAR
    pulse(4'b1000);
    pulse(4'b1000);
    wait_state(ST_PLAY, 40, "g4_play");
    pulse(4'b0010);
    t0 = ticks_total;
    n = 0;
    while (ticks_total - t0 < 2 && n < 40) begin @(negedge clk); n++; end
    chk("clear_tick2_reached", ticks_total - t0, 2);
    #1 rst = 1'b1;
    #1;
    chk("arst_state", int'(gif.state), 0);
    chk("arst_stage", int'(gif.stage_idx), 0);
    chk("arst_lives", int'(gif.lives), 2);
    chk("arst_outs", int'({gif.run, gif.load_stage, gif.serve, gif.life_lost}), 0);
    idle(2);
    rst = 1'b0;
    idle(1);
    chk("post_rst_state", int'(gif.state), 0);
    chk("post_rst_outs", int'({gif.stage_idx, gif.lives, gif.load_stage, gif.serve, gif.life_lost}), 8'b000_010_00 << 1);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter NUM_STAGES, default 3, number of stages played before WIN (legal 1..8).
REQ-002 Parameter LIVES, default 3, lives granted at game start (legal 1..7).
REQ-003 Parameter SERVE_TICKS, default 20, ticks spent in SERVE before the ball is released (legal 1..255).
REQ-004 Parameter CLEAR_TICKS, default 40, ticks spent in CLEAR between stages (legal 1..255).
REQ-005 clk  in  1  system clock; one clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 tick  in  1  game-tick strobe, one clk wide; qualifies the SERVE/CLEAR timers only.
REQ-008 start  in  1  debounced one-cycle start pulse.
REQ-009 pause  in  1  debounced one-cycle pause toggle pulse.
REQ-010 bricks_empty  in  1  level, high when the current stage has no bricks left.
REQ-011 ball_lost  in  1  one-cycle pulse, ball passed below the paddle.
REQ-012 state  out  3  current game state (package encoding).
REQ-013 stage_idx  out  3  current stage, 0-based.
REQ-014 lives  out  3  remaining lives.
REQ-015 run  out  1  physics enable; high only in PLAY.
REQ-016 load_stage  out  1  one-cycle pulse: reload brick map for stage_idx.
REQ-017 serve  out  1  one-cycle pulse: reset ball to serve position/velocity.
REQ-018 life_lost  out  1  one-cycle pulse for audio/UI.

Function
REQ-019 States: MENU, SERVE, PLAY, PAUSE, CLEAR, WIN, LOSE; registered outputs, effective the cycle after the triggering input.
REQ-020 MENU: start -> SERVE; stage_idx<=0; lives<=LIVES; load_stage and serve pulse in the same cycle state becomes SERVE.
REQ-021 SERVE: 8-bit timer cleared on entry, incremented on tick; when timer reaches SERVE_TICKS-1 and tick high -> PLAY.
REQ-022 PLAY: run=1; event priority bricks_empty > ball_lost > pause, one event acted on per cycle, lower-priority events that cycle discarded.
REQ-023 PLAY, bricks_empty: stage_idx==NUM_STAGES-1 -> WIN, else -> CLEAR.
REQ-024 PLAY, ball_lost: life_lost pulses; lives==1 -> lives<=0, LOSE; else lives<=lives-1, serve pulses, -> SERVE.
REQ-025 PLAY, pause -> PAUSE; PAUSE, pause -> PLAY; all other inputs ignored in PAUSE; timers hold.
REQ-026 CLEAR: timer as SERVE with CLEAR_TICKS; on expiry stage_idx<=stage_idx+1, load_stage and serve pulse, -> SERVE.
REQ-027 WIN, LOSE: start -> MENU; stage_idx and lives hold their values until next game start.
REQ-028 start ignored outside MENU/WIN/LOSE; ball_lost and bricks_empty ignored outside PLAY.
REQ-029 tick and event coincident: event handled, tick has no effect on timers outside SERVE/CLEAR.
REQ-030 stage_idx never exceeds NUM_STAGES-1; lives never wraps below 0.

Reset
REQ-031 rst forces state=MENU, stage_idx=0, lives=LIVES, timer=0, run=0, load_stage=serve=life_lost=0, immediately and independent of clk.
REQ-032 rst asserted mid-SERVE/CLEAR/PLAY abandons the game; first cycle after release is MENU with no pulse outputs.

Structure
REQ-033 State encoding constants (MENU=0, WIN=1, LOSE=2, PLAY=3, SERVE=4, PAUSE=5, CLEAR=6) live in the shared game package used by rendering and audio.
REQ-034 One sub-module, tick_timer (8-bit, clear, tick enable, terminal-count compare), instanced once and shared by SERVE and CLEAR.

Verification (NUM_STAGES=2, LIVES=2, SERVE_TICKS=3, CLEAR_TICKS=4, tick every 4 clk)
REQ-035 Reset then start -> state SERVE, stage_idx 0, lives 2, load_stage and serve each high exactly 1 cycle; PLAY after 3rd tick, run=1.
REQ-036 PLAY, ball_lost twice (re-serving between) -> lives 2->1->0, life_lost 2 pulses, final state LOSE, run=0; start -> MENU.
REQ-037 PLAY, bricks_empty on stage 0 -> CLEAR; after 4 ticks stage_idx 1, load_stage pulse, SERVE; bricks_empty on stage 1 in PLAY -> WIN.
REQ-038 PLAY, bricks_empty and ball_lost same cycle -> CLEAR, lives unchanged, no life_lost pulse.
REQ-039 PLAY, pause -> PAUSE, run=0, ball_lost ignored, lives unchanged; pause -> PLAY.
REQ-040 rst asserted mid-CLEAR at tick 2 -> outputs at reset values asynchronously; after release state MENU, stage_idx 0, lives 2.
